gpu_mem_cpuvram_fifo_1w2r: RTL and testbench

Readback FIFO for the VRAM→CPU path. Each 32-bit VRAM read word enters as two 16-bit pixels in one write. Pixels leave one or two per cycle toward the CPU/GP0 read port. An optional low-half skip lets a transfer start on an odd pixel address. A synchronous flush clears the FIFO when a transfer is aborted.

---
 rtl/gpu_mem_cpuvram_fifo_1w2r.sv | 130 +++++++++++++
 tb/tb_gpu_mem_cpuvram_fifo_1w2r.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_cpuvram_fifo_1w2r.sv
//============================================================================
// Module   : gpu_mem_cpuvram_fifo_1w2r
// Brief    : VRAM->CPU readback FIFO. One 32-bit word (two pixels) in per
//            cycle, with optional low-pixel skip; one or two pixels out per
//            cycle. Optional level_o port under GPU_CPUFIFO_LEVEL_EN.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module gpu_mem_cpuvram_fifo_1w2r #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 push_i,
    input  logic [2*WIDTH-1:0]   data_in_i,
    input  logic                 skip_lo_i,
    input  logic                 flush_i,
    input  logic                 pop0_i,
    input  logic                 pop1_i,
    output logic                 accept_o,
    output logic                 valid0_o,
    output logic                 valid1_o,
    output logic [WIDTH-1:0]     data0_o,
    output logic [WIDTH-1:0]     data1_o
`ifdef GPU_CPUFIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]      level_o
`endif
);

    localparam logic [ADDR_W:0]   c_accept_max = (ADDR_W+1)'(DEPTH - 2);
    localparam logic [ADDR_W:0]   c_cnt_two    = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] c_step_one   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_step_two   = ADDR_W'(2);

    logic [WIDTH-1:0]  ram_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              w_accept;
    logic              w_push_ok;
    logic              w_valid0;
    logic              w_valid1;
    logic [ADDR_W-1:0] w_in_step;
    logic [ADDR_W-1:0] w_out_step;
    logic              w_we_a;
    logic              w_we_b;
    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;
    logic [WIDTH-1:0]  w_wdata_a;
    logic [WIDTH-1:0]  w_wdata_b;
    logic [ADDR_W-1:0] w_rd_next;

    // Space check uses registered count only; a same-cycle pop frees nothing.
    always_comb begin
        w_accept   = (count_q <= c_accept_max) & ~flush_i;
        w_push_ok  = push_i & w_accept;
        w_valid0   = (count_q != '0);
        w_valid1   = (count_q >= c_cnt_two);

        w_in_step  = '0;
        if (w_push_ok) begin
            w_in_step = skip_lo_i ? c_step_one : c_step_two;
        end

        w_out_step = '0;
        if (pop0_i && w_valid0) begin
            w_out_step = (pop1_i && w_valid1) ? c_step_two : c_step_one;
        end

        wr_ptr_d = wr_ptr_q + w_in_step;
        rd_ptr_d = rd_ptr_q + w_out_step;
        count_d  = count_q + {1'b0, w_in_step} - {1'b0, w_out_step};

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // A skipped push lands the high pixel in the slot the low pixel would use.
    always_comb begin
        w_we_a    = w_push_ok;
        w_we_b    = w_push_ok & ~skip_lo_i;
        w_addr_a  = wr_ptr_q;
        w_addr_b  = wr_ptr_q + c_step_one;
        w_wdata_a = skip_lo_i ? data_in_i[2*WIDTH-1:WIDTH] : data_in_i[WIDTH-1:0];
        w_wdata_b = data_in_i[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (w_we_a) begin
            ram_q[w_addr_a] <= w_wdata_a;
        end
        if (w_we_b) begin
            ram_q[w_addr_b] <= w_wdata_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign w_rd_next = rd_ptr_q + c_step_one;
    assign accept_o  = w_accept;
    assign valid0_o  = w_valid0;
    assign valid1_o  = w_valid1;
    assign data0_o   = ram_q[rd_ptr_q];
    assign data1_o   = ram_q[w_rd_next];

`ifdef GPU_CPUFIFO_LEVEL_EN
    assign level_o   = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpu_mem_cpuvram_fifo_1w2r.sv
//============================================================================
// Module   : tb_gpu_mem_cpuvram_fifo_1w2r
// Brief    : Self-checking bench: vector table, corner sequences, and
//            randomized traffic against a pixel-queue reference model.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_gpu_mem_cpuvram_fifo_1w2r;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [31:0] din = '0;
    logic        skip = 1'b0;
    logic        flush = 1'b0;
    logic        pop0 = 1'b0;
    logic        pop1 = 1'b0;
    logic        accept;
    logic        valid0;
    logic        valid1;
    logic [15:0] data0;
    logic [15:0] data1;
`ifdef GPU_CPUFIFO_LEVEL_EN
    logic [3:0]  level;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    gpu_mem_cpuvram_fifo_1w2r #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .push_i    (push),
        .data_in_i (din),
        .skip_lo_i (skip),
        .flush_i   (flush),
        .pop0_i    (pop0),
        .pop1_i    (pop1),
        .accept_o  (accept),
        .valid0_o  (valid0),
        .valid1_o  (valid1),
        .data0_o   (data0),
        .data1_o   (data1)
`ifdef GPU_CPUFIFO_LEVEL_EN
        ,
        .level_o   (level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        skip;
        logic        flush;
        logic        pop0;
        logic        pop1;
        logic [31:0] din;
        logic        e_acc;
        logic        e_v0;
        logic        e_v1;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain queue of stored pixels, oldest first.
    logic [15:0] mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic pu, input logic sk, input logic fl, input logic p0,
                       input logic p1, input logic [31:0] d, input logic ea,
                       input logic ev0, input logic ev1, input logic [15:0] ed0,
                       input logic [15:0] ed1, input int ec);
        vec_t v;
        v.push = pu; v.skip = sk; v.flush = fl; v.pop0 = p0; v.pop1 = p1; v.din = d;
        v.e_acc = ea; v.e_v0 = ev0; v.e_v1 = ev1; v.e_d0 = ed0; v.e_d1 = ed1; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        push = 0; skip = 0; flush = 0; pop0 = 0; pop1 = 0; din = '0;
    endtask

    task automatic check_level(input string name, input int exp);
`ifdef GPU_CPUFIFO_LEVEL_EN
        chk(name, 32'(level), 32'(exp));
`endif
    endtask

    // Apply inputs for one edge, then observe the resulting state.
    task automatic cycle(input logic pu, input logic sk, input logic fl,
                         input logic p0, input logic p1, input logic [31:0] d);
        push = pu; skip = sk; flush = fl; pop0 = p0; pop1 = p1; din = d;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic model_step(input logic pu, input logic sk, input logic fl,
                              input logic p0, input logic p1, input logic [31:0] d);
        int sz;
        int nout;
        logic acc;
        sz   = mq.size();
        acc  = (sz <= 6) && !fl;
        nout = 0;
        if (p0 && sz >= 1) nout = 1;
        if (p0 && p1 && sz >= 2) nout = 2;
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < nout; i++) void'(mq.pop_front());
            if (pu && acc) begin
                if (!sk) mq.push_back(d[15:0]);
                mq.push_back(d[31:16]);
            end
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".accept"}, 32'(accept), 32'((sz <= 6) && !flush));
        chk({tag, ".valid0"}, 32'(valid0), 32'(sz >= 1));
        chk({tag, ".valid1"}, 32'(valid1), 32'(sz >= 2));
        if (sz >= 1) chk({tag, ".data0"}, 32'(data0), 32'(mq[0]));
        if (sz >= 2) chk({tag, ".data1"}, 32'(data1), 32'(mq[1]));
        check_level({tag, ".level"}, sz);
    endtask

    initial begin
        // push skip flush pop0 pop1 din | acc v0 v1 d0 d1 cnt
        add(0,0,0,0,0,32'h0,          1,0,0,16'h0,   16'h0,   0);
        add(1,0,0,0,0,32'hBBBB_AAAA,  1,1,1,16'hAAAA,16'hBBBB,2);
        add(0,0,0,1,1,32'h0,          1,0,0,16'h0,   16'h0,   0);
        add(1,1,0,0,0,32'h2222_1111,  1,1,0,16'h2222,16'h0,   1);
        add(1,0,0,0,0,32'h4444_3333,  1,1,1,16'h2222,16'h3333,3);
        add(0,0,0,1,0,32'h0,          1,1,1,16'h3333,16'h4444,2);
        add(0,0,0,1,1,32'h0,          1,0,0,16'h0,   16'h0,   0);
        add(1,0,0,0,0,32'h0002_0001,  1,1,1,16'h0001,16'h0002,2);
        add(1,0,0,0,0,32'h0004_0003,  1,1,1,16'h0001,16'h0002,4);
        add(1,0,0,0,0,32'h0006_0005,  1,1,1,16'h0001,16'h0002,6);
        add(1,0,0,0,0,32'h0008_0007,  0,1,1,16'h0001,16'h0002,8);
        add(1,0,0,0,0,32'h000A_0009,  0,1,1,16'h0001,16'h0002,8);
        add(0,0,0,0,1,32'h0,          0,1,1,16'h0001,16'h0002,8);
        add(0,0,0,1,0,32'h0,          0,1,1,16'h0002,16'h0003,7);
        add(0,0,0,1,0,32'h0,          1,1,1,16'h0003,16'h0004,6);
        add(1,1,0,0,0,32'h000C_000B,  0,1,1,16'h0003,16'h0004,7);
        add(0,0,0,1,1,32'h0,          1,1,1,16'h0005,16'h0006,5);
        add(0,0,0,1,1,32'h0,          1,1,1,16'h0007,16'h0008,3);
        add(0,0,0,1,1,32'h0,          1,1,0,16'h000C,16'h0,   1);
        add(0,0,0,1,1,32'h0,          1,0,0,16'h0,   16'h0,   0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.accept", 32'(accept), 32'd1);
        chk("reset.valid0", 32'(valid0), 32'd0);
        chk("reset.valid1", 32'(valid1), 32'd0);
        check_level("reset.level", 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].push, vecs[i].skip, vecs[i].flush, vecs[i].pop0, vecs[i].pop1, vecs[i].din);
            chk($sformatf("vec%0d.accept", i), 32'(accept), 32'(vecs[i].e_acc));
            chk($sformatf("vec%0d.valid0", i), 32'(valid0), 32'(vecs[i].e_v0));
            chk($sformatf("vec%0d.valid1", i), 32'(valid1), 32'(vecs[i].e_v1));
            if (vecs[i].e_v0) chk($sformatf("vec%0d.data0", i), 32'(data0), 32'(vecs[i].e_d0));
            if (vecs[i].e_v1) chk($sformatf("vec%0d.data1", i), 32'(data1), 32'(vecs[i].e_d1));
            check_level($sformatf("vec%0d.level", i), vecs[i].e_cnt);
        end

        // Wrap: steady push + dual pop keeps two pixels, crossing index 7->0.
        for (int k = 0; k < 10; k++) begin
            logic [15:0] lo;
            logic [15:0] hi;
            lo = 16'(16'h1000 + 2 * k);
            hi = 16'(16'h1000 + 2 * k + 1);
            cycle(1, 0, 0, 1, 1, {hi, lo});
            chk($sformatf("wrap%0d.data0", k), 32'(data0), 32'(lo));
            chk($sformatf("wrap%0d.data1", k), 32'(data1), 32'(hi));
            chk($sformatf("wrap%0d.valid1", k), 32'(valid1), 32'd1);
        end

        // Simultaneous push and single pop at count 3, then flush overriding both.
        cycle(0, 0, 1, 0, 0, 32'h0);
        chk("flush0.valid0", 32'(valid0), 32'd0);
        cycle(1, 1, 0, 0, 0, 32'h5555_0000);
        cycle(1, 0, 0, 0, 0, 32'h7777_6666);
        check_level("sim.level3", 3);
        cycle(1, 0, 0, 1, 0, 32'h9999_8888);
        chk("sim.data0", 32'(data0), 32'h6666);
        chk("sim.data1", 32'(data1), 32'h7777);
        check_level("sim.level4", 4);
        push = 1; flush = 1; pop0 = 1; pop1 = 1; din = 32'hDEAD_BEEF;
        #1;
        chk("flush.accept_during", 32'(accept), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("flush.valid0", 32'(valid0), 32'd0);
        chk("flush.valid1", 32'(valid1), 32'd0);
        chk("flush.accept_after", 32'(accept), 32'd1);
        check_level("flush.level", 0);

        // Asynchronous reset with five pixels stored.
        cycle(1, 0, 0, 0, 0, 32'h0B0B_0A0A);
        cycle(1, 0, 0, 0, 0, 32'h0D0D_0C0C);
        cycle(1, 1, 0, 0, 0, 32'h0F0F_0E0E);
        check_level("areset.level5", 5);
        chk("areset.pre_valid1", 32'(valid1), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.valid0", 32'(valid0), 32'd0);
        chk("areset.valid1", 32'(valid1), 32'd0);
        chk("areset.accept", 32'(accept), 32'd1);
        check_level("areset.level", 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            logic        pu;
            logic        sk;
            logic        fl;
            logic        p0;
            logic        p1;
            logic [31:0] d;
            @(negedge clk);
            pu = ($urandom_range(0, 99) < 60);
            sk = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 3);
            p0 = ($urandom_range(0, 99) < 55);
            p1 = ($urandom_range(0, 99) < 60);
            d  = $urandom;
            push = pu; skip = sk; flush = fl; pop0 = p0; pop1 = p1; din = d;
            #1;
            check_model($sformatf("rnd%0d", n));
            @(posedge clk);
            model_step(pu, sk, fl, p0, p1, d);
            #1;
            idle_inputs();
        end
        #1;
        check_model("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
